// File: rtl/audio_pingpong_buffer.sv
// Ping-pong frame buffer between a stereo codec stream and an FFT engine.
// One bank fills with the latched channel while the other is held for the FFT.
module audio_pingpong_buffer #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_valid_i,
  input  logic [DATA_BITS-1:0] sample_left_i,
  input  logic [DATA_BITS-1:0] sample_right_i,
  input  logic                 channel_select_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o,
  output logic                 start_o,
  input  logic                 done_i,
  output logic                 rd_busy_o,
  output logic                 wr_bank_o,
  output logic [7:0]           overrun_cnt_o
);

  localparam int DEPTH = 2 ** (ADDR_BITS + 1);

  logic [DATA_BITS-1:0] mem_q [DEPTH];

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_busy_q, rd_busy_d;
  logic                 start_q, start_d;
  logic                 chan_q, chan_d;
  logic [7:0]           overrun_q, overrun_d;
  logic [DATA_BITS-1:0] rd_data_q;

  logic                 wr_en;
  logic                 use_right;
  logic [DATA_BITS-1:0] wr_data;
  logic                 busy_after_done;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    start_d   = 1'b0;
    chan_d    = chan_q;
    overrun_d = overrun_q;
    wr_en     = sample_valid_i && !rst;

    // The write to address 0 uses the live select; the rest of the frame uses the latch.
    use_right = (wr_ptr_q == '0) ? channel_select_i : chan_q;
    wr_data   = use_right ? sample_right_i : sample_left_i;

    // A release in the same cycle as frame-full is applied before the swap decision.
    busy_after_done = rd_busy_q && !done_i;
    rd_busy_d       = busy_after_done;

    if (sample_valid_i) begin
      wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      if (wr_ptr_q == '0) chan_d = channel_select_i;
      if (&wr_ptr_q) begin
        if (!busy_after_done) begin
          wr_bank_d = ~wr_bank_q;
          rd_busy_d = 1'b1;
          start_d   = 1'b1;
        end else if (overrun_q != 8'hFF) begin
          overrun_d = overrun_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_busy_q <= 1'b0;
      start_q   <= 1'b0;
      chan_q    <= 1'b0;
      overrun_q <= 8'd0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_bank_q <= wr_bank_d;
      rd_busy_q <= rd_busy_d;
      start_q   <= start_d;
      chan_q    <= chan_d;
      overrun_q <= overrun_d;
      rd_data_q <= mem_q[{~wr_bank_q, rd_addr_i}];
    end
  end

  // NOTE: the sample RAM has no reset so it maps onto block RAM; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_bank_q, wr_ptr_q}] <= wr_data;
  end

  assign rd_data_o     = rd_data_q;
  assign start_o       = start_q;
  assign rd_busy_o     = rd_busy_q;
  assign wr_bank_o     = wr_bank_q;
  assign overrun_cnt_o = overrun_q;

endmodule

// File: tb/tb_audio_pingpong_buffer.sv
// Randomized bench for audio_pingpong_buffer against a frame-level reference model.
// A second, small-frame instance exercises overrun counter saturation.
module tb_audio_pingpong_buffer;

  localparam int FRAME   = 1024;
  localparam int S_FRAME = 8;

  logic        clk;
  logic        rst, valid, sel, done;
  logic [15:0] left, right;
  logic [9:0]  rd_addr;
  logic [15:0] rd_data;
  logic        start, rd_busy, wr_bank;
  logic [7:0]  ovr;

  logic        s_rst, s_valid, s_done;
  logic [15:0] s_left;
  logic [2:0]  s_rd_addr;
  logic [15:0] s_rd_data;
  logic        s_start, s_busy, s_bank;
  logic [7:0]  s_ovr;

  int errors = 0;
  int checks = 0;

  // Reference model: two frame banks plus who owns which.
  logic [15:0] m_bank  [2][FRAME];
  bit          m_known [2][FRAME];
  int          m_ptr;
  bit          m_wb, m_busy, m_start, m_chan;
  int          m_ovr;
  logic [15:0] exp_frame [FRAME];

  audio_pingpong_buffer #(.ADDR_BITS(10), .DATA_BITS(16)) u_dut (
    .clk(clk), .rst(rst), .sample_valid_i(valid), .sample_left_i(left),
    .sample_right_i(right), .channel_select_i(sel), .rd_addr_i(rd_addr),
    .rd_data_o(rd_data), .start_o(start), .done_i(done), .rd_busy_o(rd_busy),
    .wr_bank_o(wr_bank), .overrun_cnt_o(ovr)
  );

  audio_pingpong_buffer #(.ADDR_BITS(3), .DATA_BITS(16)) u_dut_small (
    .clk(clk), .rst(s_rst), .sample_valid_i(s_valid), .sample_left_i(s_left),
    .sample_right_i(~s_left), .channel_select_i(1'b0), .rd_addr_i(s_rd_addr),
    .rd_data_o(s_rd_data), .start_o(s_start), .done_i(s_done), .rd_busy_o(s_busy),
    .wr_bank_o(s_bank), .overrun_cnt_o(s_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus, then model update and per-cycle comparisons.
  task automatic cycle(input bit v, input logic [15:0] lv, input logic [15:0] rv,
                       input bit s, input bit d, input bit rs, input logic [9:0] ra);
    logic [15:0] exp_rd;
    bit          chk_rd;
    @(negedge clk);
    rst = rs; valid = v; left = lv; right = rv; sel = s; done = d; rd_addr = ra;
    @(posedge clk);
    #1;
    if (rs) begin
      m_ptr = 0; m_wb = 0; m_busy = 0; m_start = 0; m_chan = 0; m_ovr = 0;
      exp_rd = '0; chk_rd = 1;
    end else begin
      chk_rd  = m_known[!m_wb][ra];
      exp_rd  = m_bank[!m_wb][ra];
      m_start = 0;
      if (d) m_busy = 0;
      if (v) begin
        if (m_ptr == 0) m_chan = s;
        m_bank[m_wb][m_ptr]  = m_chan ? rv : lv;
        m_known[m_wb][m_ptr] = 1;
        m_ptr++;
        if (m_ptr == FRAME) begin
          m_ptr = 0;
          if (m_busy) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
          else begin m_wb = !m_wb; m_busy = 1; m_start = 1; end
        end
      end
    end
    checks++;
    if (start !== m_start) begin
      errors++; $display("FAIL start_o: got %b expected %b at %0t", start, m_start, $time);
    end
    checks++;
    if (wr_bank !== m_wb) begin
      errors++; $display("FAIL wr_bank_o: got %b expected %b at %0t", wr_bank, m_wb, $time);
    end
    checks++;
    if (rd_busy !== m_busy) begin
      errors++; $display("FAIL rd_busy_o: got %b expected %b at %0t", rd_busy, m_busy, $time);
    end
    checks++;
    if (ovr !== 8'(m_ovr)) begin
      errors++; $display("FAIL overrun_cnt_o: got %0d expected %0d at %0t", ovr, m_ovr, $time);
    end
    if (chk_rd) begin
      checks++;
      if (rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rd_data_o[%0d]: got %h expected %h at %0t", ra, rd_data, exp_rd, $time);
      end
    end
  endtask

  task automatic idle(input logic [9:0] ra);
    cycle(0, 16'($urandom), 16'($urandom), 0, 0, 0, ra);
  endtask

  task automatic read_back(input string name, input int n);
    logic [9:0] ra;
    for (int j = 0; j < n; j++) begin
      ra = (j == 0) ? 10'd0 : (j == 1) ? 10'd1023 : 10'($urandom);
      idle(ra);
      checks++;
      if (rd_data !== exp_frame[ra]) begin
        errors++;
        $display("FAIL %s addr %0d: got %h expected %h", name, ra, rd_data, exp_frame[ra]);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) cycle(1, 16'($urandom), 16'($urandom), 1, 1, 1, 10'($urandom));
    checks++;
    if ({start, wr_bank, rd_busy, ovr, rd_data} !== '0) begin
      errors++;
      $display("FAIL reset_state: got start=%b bank=%b busy=%b ovr=%0d rd=%h expected all 0",
               start, wr_bank, rd_busy, ovr, rd_data);
    end
  endtask

  task automatic test_first_frame();
    int starts = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle(1, 16'(i), ~16'(i), 0, 0, 0, 10'($urandom));
      starts += int'(start);
      exp_frame[i] = 16'(i);
    end
    idle(0);
    starts += int'(start);
    checks++;
    if (starts != 1 || wr_bank !== 1'b1 || rd_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_frame: got starts=%0d bank=%b busy=%b expected 1/1/1", starts, wr_bank, rd_busy);
    end
    read_back("first_frame_read", 12);
  endtask

  task automatic test_overrun();
    int starts = 0;
    for (int i = 0; i < FRAME; i++) begin
      cycle(1, 16'($urandom), 16'($urandom), 1'($urandom), 0, 0, 10'($urandom));
      starts += int'(start);
    end
    checks++;
    if (ovr !== 8'd1 || starts != 0 || wr_bank !== 1'b1) begin
      errors++;
      $display("FAIL overrun: got ovr=%0d starts=%0d bank=%b expected 1/0/1", ovr, starts, wr_bank);
    end
    read_back("overrun_read_stable", 12);
  endtask

  task automatic test_release_right();
    int starts = 0;
    logic [15:0] lv, rv;
    cycle(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < FRAME; i++) begin
      lv = 16'($urandom); rv = 16'($urandom);
      cycle(1, lv, rv, 1, 0, 0, 10'($urandom));
      starts += int'(start);
      exp_frame[i] = rv;
    end
    checks++;
    if (starts != 1 || wr_bank !== 1'b0 || ovr !== 8'd1) begin
      errors++;
      $display("FAIL release_right: got starts=%0d bank=%b ovr=%0d expected 1/0/1", starts, wr_bank, ovr);
    end
    read_back("right_channel_read", 12);
  endtask

  task automatic test_channel_latch();
    int starts = 0;
    logic [15:0] lv, rv;
    cycle(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < FRAME; i++) begin
      lv = 16'($urandom); rv = 16'($urandom);
      cycle(1, lv, rv, i >= 500, 0, 0, 10'($urandom));
      starts += int'(start);
      exp_frame[i] = lv;
    end
    checks++;
    if (starts != 1 || wr_bank !== 1'b1) begin
      errors++;
      $display("FAIL channel_latch_swap: got starts=%0d bank=%b expected 1/1", starts, wr_bank);
    end
    read_back("channel_latch_read", 8);
    for (int a = 498; a < 503; a++) begin
      idle(10'(a));
      checks++;
      if (rd_data !== exp_frame[a]) begin
        errors++;
        $display("FAIL channel_latch_toggle addr %0d: got %h expected %h", a, rd_data, exp_frame[a]);
      end
    end
  endtask

  task automatic test_done_same_cycle();
    int starts = 0;
    int ovr_before = int'(ovr);
    logic [15:0] lv, rv;
    for (int i = 0; i < FRAME; i++) begin
      lv = 16'($urandom); rv = 16'($urandom);
      cycle(1, lv, rv, (i == 0) || (i >= 500 && i < 600) ? 1'b1 : 1'b0, i == FRAME - 1, 0, 10'($urandom));
      starts += int'(start);
      exp_frame[i] = rv;
    end
    checks++;
    if (starts != 1 || int'(ovr) != ovr_before || rd_busy !== 1'b1 || wr_bank !== 1'b0) begin
      errors++;
      $display("FAIL done_same_cycle: got starts=%0d ovr=%0d busy=%b bank=%b expected 1/%0d/1/0",
               starts, ovr, rd_busy, wr_bank, ovr_before);
    end
    read_back("done_same_cycle_read", 8);
  endtask

  task automatic test_reset_midframe();
    int start_at = -1;
    for (int i = 0; i < 300; i++) cycle(1, 16'($urandom), 16'($urandom), 0, 0, 0, 10'($urandom));
    cycle(1, 16'($urandom), 16'($urandom), 1, 1, 1, 10'($urandom));
    for (int i = 0; i < FRAME; i++) begin
      cycle(1, 16'($urandom), 16'($urandom), 0, 0, 0, 10'($urandom));
      if (start === 1'b1 && start_at < 0) start_at = i + 1;
    end
    checks++;
    if (start_at != FRAME || wr_bank !== 1'b1 || ovr !== 8'd0) begin
      errors++;
      $display("FAIL reset_midframe: got start after %0d strobes bank=%b ovr=%0d expected %0d/1/0",
               start_at, wr_bank, ovr, FRAME);
    end
  endtask

  task automatic test_saturation();
    int exp_ovr;
    @(negedge clk);
    s_rst = 1; s_valid = 0; s_done = 0;
    @(negedge clk);
    s_rst = 0;
    for (int f = 1; f <= 301; f++) begin
      for (int i = 0; i < S_FRAME; i++) begin
        @(negedge clk);
        s_valid = 1; s_left = 16'($urandom); s_rd_addr = 3'($urandom);
        @(posedge clk);
        #1;
      end
      exp_ovr = (f - 1 > 255) ? 255 : f - 1;
      checks++;
      if (s_ovr !== 8'(exp_ovr) || s_busy !== 1'b1) begin
        errors++;
        $display("FAIL saturation frame %0d: got ovr=%0d busy=%b expected %0d/1", f, s_ovr, s_busy, exp_ovr);
      end
    end
    @(negedge clk);
    s_valid = 0;
  endtask

  initial begin
    rst = 1; valid = 0; sel = 0; done = 0; left = 0; right = 0; rd_addr = 0;
    s_rst = 1; s_valid = 0; s_done = 0; s_left = 0; s_rd_addr = 0;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < FRAME; a++) m_known[b][a] = 0;
    test_reset();
    test_first_frame();
    test_overrun();
    test_release_right();
    test_channel_latch();
    test_done_same_cycle();
    test_reset_midframe();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_pingpong_buffer.md
AUDIO_PINGPONG_BUFFER -- requirements
Module: audio_pingpong_buffer

Interface
REQ-001 Parameter ADDR_BITS, default 10, log2 of frame length in samples (1024).
REQ-002 Parameter DATA_BITS, default 16, sample width in bits, two's complement.
REQ-003 Port clk, input, 1, single system clock; every register is clocked on the rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-005 Port sample_valid_i, input, 1, one-cycle strobe that marks a new stereo sample pair from the codec deserialiser.
REQ-006 Port sample_left_i, input, DATA_BITS, left-channel sample; valid when sample_valid_i=1.
REQ-007 Port sample_right_i, input, DATA_BITS, right-channel sample; valid when sample_valid_i=1.
REQ-008 Port channel_select_i, input, 1, channel to capture: 0 = left, 1 = right.
REQ-009 Port rd_addr_i, input, ADDR_BITS, FFT-side read address into the read bank.
REQ-010 Port rd_data_o, output, DATA_BITS, registered read data.
REQ-011 Port start_o, output, 1, one-cycle pulse that tells the FFT a full frame is available.
REQ-012 Port done_i, input, 1, one-cycle pulse from the FFT that releases the read bank.
REQ-013 Port rd_busy_o, output, 1, high while the read bank is owned by the FFT.
REQ-014 Port wr_bank_o, output, 1, index of the bank currently being written.
REQ-015 Port overrun_cnt_o, output, 8, saturating count of discarded frames.

Function
REQ-016 Storage: two banks of 2^ADDR_BITS x DATA_BITS words, addressed as {bank, addr}; inferable as one simple dual-port RAM.
REQ-017 Channel latch: channel_select_i is sampled only on the write to address 0; that channel is used for the whole frame, so no frame mixes channels.
REQ-018 Write: on each sample_valid_i=1, write the selected channel sample to {wr_bank, wr_ptr}, then wr_ptr += 1, wrapping from 2^ADDR_BITS-1 to 0.
REQ-019 Frame full: the write to address 2^ADDR_BITS-1 completes a frame.
REQ-020 Swap: at frame full with rd_busy_o=0 (as evaluated in that same cycle), next cycle:
  - wr_bank_o toggles;
  - rd_busy_o = 1;
  - start_o = 1 for exactly one cycle.
REQ-021 Overrun: at frame full with rd_busy_o=1:
  - no swap;
  - the write bank is refilled from address 0, discarding the frame;
  - overrun_cnt_o increments, saturating at 255.
REQ-022 Release: done_i=1 clears rd_busy_o on the next edge; done_i while rd_busy_o=0 is ignored.
REQ-023 Simultaneous done_i and frame full: done_i is applied first, so the swap of REQ-020 occurs with no overrun, and rd_busy_o stays 1.
REQ-024 Read port: rd_data_o = mem[{~wr_bank, rd_addr_i}], registered, one-cycle latency.
  - Reads are allowed at any time.
  - The read bank is never written, so data is stable between start_o and done_i.
REQ-025 sample_valid_i held high on consecutive cycles writes one sample per cycle with no loss.
REQ-026 rd_busy_o, wr_bank_o and start_o are driven directly from registers, with no combinational path from any input.

Reset
REQ-027 rst=1 sets wr_ptr=0, wr_bank_o=0, rd_busy_o=0, start_o=0, rd_data_o=0, overrun_cnt_o=0, and the latched channel to 0.
REQ-028 Reset mid-frame discards the partial frame and any FFT ownership.
  - RAM contents are not cleared.
  - The first frame after reset always swaps, because the read bank is free.
REQ-029 While rst=1, sample_valid_i and done_i are ignored.

Verification
REQ-030 After reset, drive 1024 strobes with left = index, right = ~index, and channel_select_i=0.
  - Expect start_o for one cycle, wr_bank_o=1 and rd_busy_o=1.
  - Reading addr k returns k one cycle later.
REQ-031 With no done_i, drive 1024 more samples.
  - Expect overrun_cnt_o=1, no start_o, wr_bank_o still 1.
  - Read data unchanged.
REQ-032 Pulse done_i, then drive 1024 samples with channel_select_i=1.
  - Expect start_o, wr_bank_o=0 and readback of the right-channel values.
REQ-033 Toggle channel_select_i at address 500 of a frame.
  - The whole frame contains the channel latched at address 0.
REQ-034 Assert done_i in the same cycle as the 1024th strobe.
  - Expect the swap and start_o, with overrun_cnt_o unchanged.
REQ-035 Assert rst at address 300 of a frame, then stream 1024 samples.
  - Expect start_o after exactly 1024 strobes, with wr_bank_o=1.
  - Force 300 overruns: overrun_cnt_o saturates at 255.
